// File: rtl/wb_writeback_unit.sv
// ----------------------------------------------------------------------------
// wb_writeback_unit
//
// Write-back stage that merges ALU results and load-unit responses onto the
// single register-file write port (Wen / Rd_addr / write_data). ALU results
// always win the port. Loads are formatted (sign/zero extended) on acceptance
// and parked in a one-entry buffer until the port is free. The write port is
// driven from registers, and same-cycle forwarding to decode is derived
// combinationally from those registers.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   alu_valid/alu_rd/alu_data    ALU result, no backpressure
//   ld_valid/ld_ready            load response handshake
//   ld_rd/ld_funct3/ld_offset    load destination, type and byte offset
//   ld_data                      raw aligned doubleword from data memory
//   ld_err                       one-cycle pulse for an illegal/misaligned load
//   ld_pending/ld_pending_rd     load buffer occupancy and its destination
//   Wen/Rd_addr/write_data       registered register-file write port
//   Rs1_addr/Rs2_addr            decode read addresses
//   Rs1_fwd_hit/Rs2_fwd_hit      forward hit flags (never for x0)
//   Rs1_fwd_data/Rs2_fwd_data    forwarded data (the current write_data)
// ----------------------------------------------------------------------------
module wb_writeback_unit #(
  parameter int XLEN   = 64,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [REG_AW-1:0] ld_rd,
  input  logic [2:0]        ld_funct3,
  input  logic [2:0]        ld_offset,
  input  logic [XLEN-1:0]   ld_data,
  output logic              ld_err,
  output logic              ld_pending,
  output logic [REG_AW-1:0] ld_pending_rd,
  output logic              Wen,
  output logic [REG_AW-1:0] Rd_addr,
  output logic [XLEN-1:0]   write_data,
  input  logic [REG_AW-1:0] Rs1_addr,
  input  logic [REG_AW-1:0] Rs2_addr,
  output logic              Rs1_fwd_hit,
  output logic              Rs2_fwd_hit,
  output logic [XLEN-1:0]   Rs1_fwd_data,
  output logic [XLEN-1:0]   Rs2_fwd_data
);

  logic              alu_win;
  logic              buf_full;
  logic [REG_AW-1:0] buf_rd;
  logic [XLEN-1:0]   buf_data;

  logic              ld_fire;
  logic              ld_bad;
  logic              ld_store;
  logic              drain;
  logic [XLEN-1:0]   shifted;
  logic [XLEN-1:0]   fmt_data;

  // ALU writes to x0 are dropped and never take the port.
  assign alu_win = alu_valid && (alu_rd != '0);

  // The buffer can always accept when it drains this same cycle.
  assign ld_ready = !buf_full || !alu_win;
  assign ld_fire  = ld_valid && ld_ready;
  assign drain    = buf_full && !alu_win;

  // Load formatting: bring the addressed field down to bit 0, then extend.
  // funct3[2] selects zero extension, funct3[1:0] selects the access size.
  always_comb begin
    shifted  = ld_data >> {ld_offset, 3'b000};
    fmt_data = shifted;
    ld_bad   = 1'b0;
    case (ld_funct3[1:0])
      2'd0: begin
        fmt_data = {{(XLEN-8){!ld_funct3[2] && shifted[7]}}, shifted[7:0]};
      end
      2'd1: begin
        fmt_data = {{(XLEN-16){!ld_funct3[2] && shifted[15]}}, shifted[15:0]};
        ld_bad   = ld_offset[0];
      end
      2'd2: begin
        fmt_data = {{(XLEN-32){!ld_funct3[2] && shifted[31]}}, shifted[31:0]};
        ld_bad   = |ld_offset[1:0];
      end
      default: begin
        fmt_data = shifted;
        ld_bad   = (|ld_offset) || ld_funct3[2];
      end
    endcase
  end

  // Loads to x0 and erroneous loads complete the handshake but are not kept.
  assign ld_store = ld_fire && !ld_bad && (ld_rd != '0);

  // Load buffer: a new accept may coincide with a drain, keeping it full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_full <= 1'b0;
      buf_rd   <= '0;
      buf_data <= '0;
    end else begin
      if (ld_store) begin
        buf_full <= 1'b1;
        buf_rd   <= ld_rd;
        buf_data <= fmt_data;
      end else if (drain) begin
        buf_full <= 1'b0;
      end
    end
  end

  // Error pulse follows the accepting cycle by one clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_err <= 1'b0;
    end else begin
      ld_err <= ld_fire && ld_bad;
    end
  end

  // Register-file write port: ALU first, then the buffered load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Wen        <= 1'b0;
      Rd_addr    <= '0;
      write_data <= '0;
    end else begin
      if (alu_win) begin
        Wen        <= 1'b1;
        Rd_addr    <= alu_rd;
        write_data <= alu_data;
      end else if (buf_full) begin
        Wen        <= 1'b1;
        Rd_addr    <= buf_rd;
        write_data <= buf_data;
      end else begin
        Wen        <= 1'b0;
      end
    end
  end

  assign ld_pending    = buf_full;
  assign ld_pending_rd = buf_full ? buf_rd : '0;

  // Forwarding covers the cycle before the register file write is visible.
  assign Rs1_fwd_hit  = Wen && (Rd_addr == Rs1_addr) && (Rs1_addr != '0);
  assign Rs2_fwd_hit  = Wen && (Rd_addr == Rs2_addr) && (Rs2_addr != '0);
  assign Rs1_fwd_data = write_data;
  assign Rs2_fwd_data = write_data;

endmodule

// File: tb/tb_wb_writeback_unit.sv
// ----------------------------------------------------------------------------
// tb_wb_writeback_unit
//
// Self-checking bench for wb_writeback_unit: a table of load formatting
// vectors, hand-written multi-cycle sequences (ALU priority, x0 drops,
// asynchronous reset) and a randomized run against a reference model that
// keeps pending loads in a queue.
// ----------------------------------------------------------------------------
module tb_wb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [63:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [2:0]  ld_offset;
  logic [63:0] ld_data;
  logic        ld_err;
  logic        ld_pending;
  logic [4:0]  ld_pending_rd;
  logic        Wen;
  logic [4:0]  Rd_addr;
  logic [63:0] write_data;
  logic [4:0]  Rs1_addr;
  logic [4:0]  Rs2_addr;
  logic        Rs1_fwd_hit;
  logic        Rs2_fwd_hit;
  logic [63:0] Rs1_fwd_data;
  logic [63:0] Rs2_fwd_data;

  int checks = 0;
  int errors = 0;

  wb_writeback_unit #(.XLEN(64), .REG_AW(5)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd),
    .ld_funct3(ld_funct3), .ld_offset(ld_offset), .ld_data(ld_data),
    .ld_err(ld_err), .ld_pending(ld_pending), .ld_pending_rd(ld_pending_rd),
    .Wen(Wen), .Rd_addr(Rd_addr), .write_data(write_data),
    .Rs1_addr(Rs1_addr), .Rs2_addr(Rs2_addr),
    .Rs1_fwd_hit(Rs1_fwd_hit), .Rs2_fwd_hit(Rs2_fwd_hit),
    .Rs1_fwd_data(Rs1_fwd_data), .Rs2_fwd_data(Rs2_fwd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [2:0]  off;
    logic [63:0] data;
    logic [4:0]  rd;
    logic        exp_wen;
    logic        exp_err;
    logic [63:0] exp_data;
  } vec_t;

  vec_t vecs[16];

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
  } pend_t;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%016h expected 0x%016h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic a_v, input logic [4:0] a_rd, input logic [63:0] a_d,
                               input logic l_v, input logic [4:0] l_rd, input logic [2:0] f3,
                               input logic [2:0] off, input logic [63:0] l_d);
    alu_valid = a_v;
    alu_rd    = a_rd;
    alu_data  = a_d;
    ld_valid  = l_v;
    ld_rd     = l_rd;
    ld_funct3 = f3;
    ld_offset = off;
    ld_data   = l_d;
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 3'd0, 3'd0, 64'd0);
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference load formatting from the access rules: size in bytes, field
  // extraction by shifting, and extension by masking.
  function automatic void refLoad(input logic [2:0] f3, input logic [2:0] off,
                                  input logic [63:0] data, output logic legal,
                                  output logic [63:0] val);
    int nbytes;
    logic [63:0] mask;
    nbytes = 1 << f3[1:0];
    legal  = (f3 != 3'b111) && ((int'(off) % nbytes) == 0);
    val    = data >> (8 * int'(off));
    if (nbytes < 8) begin
      mask = (64'd1 << (8 * nbytes)) - 64'd1;
      val  = val & mask;
      if (!f3[2] && val[8*nbytes-1]) val = val | ~mask;
    end
  endfunction

  initial begin
    pend_t pend[$];
    logic  m_wen;
    logic [4:0] m_rd;
    logic [63:0] m_data;
    logic  m_err;
    logic  exp_ready;
    logic  legal;
    logic [63:0] val;
    logic  a_v, l_v;
    logic [4:0] a_rd, l_rd;
    logic [2:0] f3, off;
    logic [63:0] a_d, l_d;

    vecs[0]  = '{3'b000, 3'd2, 64'h00000000_80FF0000, 5'd7, 1'b1, 1'b0, 64'hFFFFFFFF_FFFFFFFF};
    vecs[1]  = '{3'b100, 3'd2, 64'h00000000_80FF0000, 5'd7, 1'b1, 1'b0, 64'h00000000_000000FF};
    vecs[2]  = '{3'b001, 3'd2, 64'h00000000_80FF0000, 5'd7, 1'b1, 1'b0, 64'hFFFFFFFF_FFFF80FF};
    vecs[3]  = '{3'b101, 3'd2, 64'h00000000_80FF0000, 5'd7, 1'b1, 1'b0, 64'h00000000_000080FF};
    vecs[4]  = '{3'b000, 3'd3, 64'h00000000_80FF0000, 5'd8, 1'b1, 1'b0, 64'hFFFFFFFF_FFFFFF80};
    vecs[5]  = '{3'b010, 3'd0, 64'h00000000_80FF0000, 5'd9, 1'b1, 1'b0, 64'hFFFFFFFF_80FF0000};
    vecs[6]  = '{3'b110, 3'd0, 64'h00000000_80FF0000, 5'd9, 1'b1, 1'b0, 64'h00000000_80FF0000};
    vecs[7]  = '{3'b011, 3'd0, 64'h01234567_89ABCDEF, 5'd31, 1'b1, 1'b0, 64'h01234567_89ABCDEF};
    vecs[8]  = '{3'b010, 3'd4, 64'h01234567_89ABCDEF, 5'd1, 1'b1, 1'b0, 64'h00000000_01234567};
    vecs[9]  = '{3'b001, 3'd6, 64'h81234567_89ABCDEF, 5'd2, 1'b1, 1'b0, 64'hFFFFFFFF_FFFF8123};
    vecs[10] = '{3'b100, 3'd7, 64'h81234567_89ABCDEF, 5'd3, 1'b1, 1'b0, 64'h00000000_00000081};
    vecs[11] = '{3'b010, 3'd2, 64'h00000000_80FF0000, 5'd7, 1'b0, 1'b1, 64'h0};
    vecs[12] = '{3'b111, 3'd0, 64'h00000000_80FF0000, 5'd7, 1'b0, 1'b1, 64'h0};
    vecs[13] = '{3'b000, 3'd0, 64'h00000000_80FF0000, 5'd0, 1'b0, 1'b0, 64'h0};
    vecs[14] = '{3'b001, 3'd1, 64'h00000000_80FF0000, 5'd7, 1'b0, 1'b1, 64'h0};
    vecs[15] = '{3'b011, 3'd4, 64'h00000000_80FF0000, 5'd7, 1'b0, 1'b1, 64'h0};

    // Reset
    rst = 1'b1;
    Rs1_addr = 5'd0;
    Rs2_addr = 5'd0;
    idle();
    repeat (2) step();
    checkOutput("reset_wen", 64'(Wen), 64'd0);
    checkOutput("reset_rd", 64'(Rd_addr), 64'd0);
    checkOutput("reset_data", write_data, 64'd0);
    checkOutput("reset_pending", 64'(ld_pending), 64'd0);
    checkOutput("reset_pending_rd", 64'(ld_pending_rd), 64'd0);
    checkOutput("reset_err", 64'(ld_err), 64'd0);
    rst = 1'b0;
    step();

    // ALU write and forwarding
    Rs1_addr = 5'd5;
    Rs2_addr = 5'd0;
    applyStimulus(1'b1, 5'd5, 64'h1234, 1'b0, 5'd0, 3'd0, 3'd0, 64'd0);
    step();
    idle();
    checkOutput("alu_wen", 64'(Wen), 64'd1);
    checkOutput("alu_rd", 64'(Rd_addr), 64'd5);
    checkOutput("alu_data", write_data, 64'h1234);
    checkOutput("fwd1_hit", 64'(Rs1_fwd_hit), 64'd1);
    checkOutput("fwd1_data", Rs1_fwd_data, 64'h1234);
    checkOutput("fwd2_hit_x0", 64'(Rs2_fwd_hit), 64'd0);
    step();
    checkOutput("alu_wen_drop", 64'(Wen), 64'd0);
    checkOutput("fwd1_hit_idle", 64'(Rs1_fwd_hit), 64'd0);
    Rs1_addr = 5'd0;

    // Load formatting table, ALU idle
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, vecs[i].rd, vecs[i].f3, vecs[i].off, vecs[i].data);
      checkOutput($sformatf("v%0d_ready", i), 64'(ld_ready), 64'd1);
      step();
      idle();
      checkOutput($sformatf("v%0d_err", i), 64'(ld_err), 64'(vecs[i].exp_err));
      checkOutput($sformatf("v%0d_pending", i), 64'(ld_pending), 64'(vecs[i].exp_wen));
      checkOutput($sformatf("v%0d_wen_early", i), 64'(Wen), 64'd0);
      step();
      checkOutput($sformatf("v%0d_wen", i), 64'(Wen), 64'(vecs[i].exp_wen));
      checkOutput($sformatf("v%0d_err_clear", i), 64'(ld_err), 64'd0);
      if (vecs[i].exp_wen) begin
        checkOutput($sformatf("v%0d_rd", i), 64'(Rd_addr), 64'(vecs[i].rd));
        checkOutput($sformatf("v%0d_data", i), write_data, vecs[i].exp_data);
      end
      step();
      checkOutput($sformatf("v%0d_wen_after", i), 64'(Wen), 64'd0);
    end

    // Load held in the buffer while the ALU streams rd=3,4,5
    applyStimulus(1'b1, 5'd3, 64'h33, 1'b1, 5'd7, 3'b000, 3'd2, 64'h00000000_80FF0000);
    checkOutput("str_ready0", 64'(ld_ready), 64'd1);
    step();
    applyStimulus(1'b1, 5'd4, 64'h44, 1'b1, 5'd9, 3'b011, 3'd0, 64'hDEADBEEF_CAFEF00D);
    checkOutput("str_ready1", 64'(ld_ready), 64'd0);
    checkOutput("str_pend1", 64'(ld_pending), 64'd1);
    checkOutput("str_pend_rd1", 64'(ld_pending_rd), 64'd7);
    checkOutput("str_rd3", 64'(Rd_addr), 64'd3);
    step();
    applyStimulus(1'b1, 5'd5, 64'h55, 1'b1, 5'd9, 3'b011, 3'd0, 64'hDEADBEEF_CAFEF00D);
    checkOutput("str_ready2", 64'(ld_ready), 64'd0);
    checkOutput("str_rd4", 64'(Rd_addr), 64'd4);
    checkOutput("str_pend_rd2", 64'(ld_pending_rd), 64'd7);
    step();
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b1, 5'd9, 3'b011, 3'd0, 64'hDEADBEEF_CAFEF00D);
    checkOutput("str_ready3", 64'(ld_ready), 64'd1);
    checkOutput("str_rd5", 64'(Rd_addr), 64'd5);
    checkOutput("str_data5", write_data, 64'h55);
    step();
    idle();
    checkOutput("str_ld_wen", 64'(Wen), 64'd1);
    checkOutput("str_ld_rd", 64'(Rd_addr), 64'd7);
    checkOutput("str_ld_data", write_data, 64'hFFFFFFFF_FFFFFFFF);
    checkOutput("str_pend_rd9", 64'(ld_pending_rd), 64'd9);
    step();
    checkOutput("str_ld2_rd", 64'(Rd_addr), 64'd9);
    checkOutput("str_ld2_data", write_data, 64'hDEADBEEF_CAFEF00D);
    step();
    checkOutput("str_end_wen", 64'(Wen), 64'd0);
    checkOutput("str_end_pend", 64'(ld_pending), 64'd0);

    // ALU write to x0 lets a buffered load drain
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b1, 5'd6, 3'b100, 3'd2, 64'h00000000_80FF0000);
    step();
    applyStimulus(1'b1, 5'd0, 64'h9999, 1'b0, 5'd0, 3'd0, 3'd0, 64'd0);
    checkOutput("x0_ready", 64'(ld_ready), 64'd1);
    step();
    idle();
    checkOutput("x0_wen", 64'(Wen), 64'd1);
    checkOutput("x0_rd", 64'(Rd_addr), 64'd6);
    checkOutput("x0_data", write_data, 64'hFF);
    applyStimulus(1'b1, 5'd0, 64'h9999, 1'b0, 5'd0, 3'd0, 3'd0, 64'd0);
    step();
    idle();
    checkOutput("x0_only_wen", 64'(Wen), 64'd0);

    // Asynchronous reset with the buffer full and Wen high
    applyStimulus(1'b1, 5'd3, 64'h77, 1'b1, 5'd10, 3'b011, 3'd0, 64'h1111);
    step();
    applyStimulus(1'b1, 5'd4, 64'h88, 1'b0, 5'd0, 3'd0, 3'd0, 64'd0);
    checkOutput("ar_pre_wen", 64'(Wen), 64'd1);
    checkOutput("ar_pre_pend", 64'(ld_pending), 64'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("ar_wen", 64'(Wen), 64'd0);
    checkOutput("ar_rd", 64'(Rd_addr), 64'd0);
    checkOutput("ar_data", write_data, 64'd0);
    checkOutput("ar_pend", 64'(ld_pending), 64'd0);
    idle();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput($sformatf("ar_stale%0d", i), 64'(Wen), 64'd0);
    end

    // Randomized run against the queue-based model
    pend.delete();
    m_wen = 1'b0;
    m_rd = 5'd0;
    m_data = 64'd0;
    m_err = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      a_v  = ($urandom_range(0, 99) < 50);
      a_rd = 5'($urandom_range(0, 7));
      a_d  = {$urandom, $urandom};
      l_v  = ($urandom_range(0, 99) < 60);
      l_rd = 5'($urandom_range(0, 7));
      f3   = 3'($urandom_range(0, 7));
      off  = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
      l_d  = {$urandom, $urandom};
      Rs1_addr = 5'($urandom_range(0, 7));
      Rs2_addr = 5'($urandom_range(0, 7));
      applyStimulus(a_v, a_rd, a_d, l_v, l_rd, f3, off, l_d);

      exp_ready = (pend.size() == 0) || !(a_v && a_rd != 0);
      checkOutput("rnd_ready", 64'(ld_ready), 64'(exp_ready));
      checkOutput("rnd_pend", 64'(ld_pending), 64'(pend.size() != 0));
      if (pend.size() != 0) checkOutput("rnd_pend_rd", 64'(ld_pending_rd), 64'(pend[0].rd));
      checkOutput("rnd_hit1", 64'(Rs1_fwd_hit), 64'(m_wen && m_rd == Rs1_addr && Rs1_addr != 0));
      checkOutput("rnd_hit2", 64'(Rs2_fwd_hit), 64'(m_wen && m_rd == Rs2_addr && Rs2_addr != 0));
      checkOutput("rnd_fwd1", Rs1_fwd_data, m_data);
      checkOutput("rnd_fwd2", Rs2_fwd_data, m_data);

      if (a_v && a_rd != 0) begin
        m_wen = 1'b1; m_rd = a_rd; m_data = a_d;
      end else if (pend.size() != 0) begin
        pend_t p;
        p = pend.pop_front();
        m_wen = 1'b1; m_rd = p.rd; m_data = p.data;
      end else begin
        m_wen = 1'b0;
      end
      m_err = 1'b0;
      if (l_v && exp_ready) begin
        refLoad(f3, off, l_d, legal, val);
        if (!legal) m_err = 1'b1;
        else if (l_rd != 0) pend.push_back('{l_rd, val});
      end

      step();
      checkOutput("rnd_wen", 64'(Wen), 64'(m_wen));
      checkOutput("rnd_rd", 64'(Rd_addr), 64'(m_rd));
      checkOutput("rnd_data", write_data, m_data);
      checkOutput("rnd_err", 64'(ld_err), 64'(m_err));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
